// File: rtl/ghash_seq_pkg.sv
// ghash_seq_pkg: shared types and helpers for the GHASH sequencing controller.
//   state_t     - controller states
//   mask_bytes  - zero every byte at or beyond nbytes (byte 0 in [127:120])
//   beat_bytes  - byte count a handshake contributes to a length counter
//   len_block   - builds the final len(A)||len(C) block from bit lengths
package ghash_seq_pkg;

    localparam int CNT_W_DEF = 36;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AAD,
        S_CT,
        S_LEN,
        S_WAIT_Y
    } state_t;

    // 0 (and anything above 16) is treated as a full 16-byte block.
    function automatic logic [4:0] norm_bytes(input logic [4:0] nbytes);
        return (nbytes == 5'd0 || nbytes > 5'd16) ? 5'd16 : nbytes;
    endfunction

    function automatic logic [127:0] mask_bytes(input logic [127:0] data,
                                                input logic [4:0]   nbytes);
        logic [127:0] m;
        logic [4:0]   n;
        n = norm_bytes(nbytes);
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < n) m[127-8*i -: 8] = data[127-8*i -: 8];
        end
        return m;
    endfunction

    // Only a last block may be short; every other beat counts as 16 bytes.
    function automatic logic [4:0] beat_bytes(input logic [4:0] nbytes,
                                              input logic       last);
        return last ? norm_bytes(nbytes) : 5'd16;
    endfunction

    function automatic logic [127:0] len_block(input logic [63:0] aad_bits,
                                               input logic [63:0] ct_bits);
        return {aad_bits, ct_bits};
    endfunction

endpackage

// File: rtl/ghash_seq.sv
// ghash_seq: sequences one GCM message through an external streaming GHASH core.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, h, has_aad, has_ct  message request (sampled only in IDLE)
//   abort                      abandon current message
//   aad_* / ct_*               AAD and ciphertext block streams (valid/ready)
//   gh_init, gh_h              core init pulse and hash subkey
//   gh_valid/ready/data/last   core data input handshake
//   gh_y, gh_y_valid           core result
//   busy                       controller not idle
//   s_valid, s_data            GHASH result strobe and held value
module ghash_seq
    import ghash_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] h,
    input  logic         has_aad,
    input  logic         has_ct,
    input  logic         abort,
    input  logic         aad_valid,
    output logic         aad_ready,
    input  logic [127:0] aad_data,
    input  logic [4:0]   aad_bytes,
    input  logic         aad_last,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [127:0] ct_data,
    input  logic [4:0]   ct_bytes,
    input  logic         ct_last,
    output logic         gh_init,
    output logic [127:0] gh_h,
    output logic         gh_valid,
    input  logic         gh_ready,
    output logic [127:0] gh_data,
    output logic         gh_last,
    input  logic [127:0] gh_y,
    input  logic         gh_y_valid,
    output logic         busy,
    output logic         s_valid,
    output logic [127:0] s_data
);

    state_t             state, state_nxt;
    logic [127:0]       h_q;
    logic               has_aad_q, has_ct_q;
    logic [CNT_W-1:0]   aad_cnt, ct_cnt;
    logic [63:0]        aad_bits, ct_bits;
    logic               aad_hs, ct_hs, start_acc;

    assign start_acc = (state == S_IDLE) && start;
    assign aad_hs    = (state == S_AAD) && aad_valid && gh_ready;
    assign ct_hs     = (state == S_CT) && ct_valid && gh_ready;
    assign aad_bits  = 64'(aad_cnt) << 3;
    assign ct_bits   = 64'(ct_cnt) << 3;

    assign gh_init = (state == S_INIT);
    assign busy    = (state != S_IDLE);
    assign gh_h    = h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gh_valid  = 1'b0;
        gh_data   = '0;
        gh_last   = 1'b0;
        aad_ready = 1'b0;
        ct_ready  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_INIT;
            S_INIT: state_nxt = has_aad_q ? S_AAD : (has_ct_q ? S_CT : S_LEN);
            S_AAD: begin
                gh_valid  = aad_valid;
                aad_ready = gh_ready;
                gh_data   = aad_last ? mask_bytes(aad_data, aad_bytes) : aad_data;
                if (aad_hs && aad_last) state_nxt = has_ct_q ? S_CT : S_LEN;
            end
            S_CT: begin
                gh_valid = ct_valid;
                ct_ready = gh_ready;
                gh_data  = ct_last ? mask_bytes(ct_data, ct_bytes) : ct_data;
                if (ct_hs && ct_last) state_nxt = S_LEN;
            end
            S_LEN: begin
                gh_valid = 1'b1;
                gh_last  = 1'b1;
                gh_data  = len_block(aad_bits, ct_bits);
                if (gh_ready) state_nxt = S_WAIT_Y;
            end
            S_WAIT_Y: if (gh_y_valid) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // abort wins over any handshake-driven transition
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    // Counters keep counting on a handshake that coincides with abort;
    // the next accepted start clears them anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            has_aad_q <= 1'b0;
            has_ct_q  <= 1'b0;
            aad_cnt   <= '0;
            ct_cnt    <= '0;
            s_valid   <= 1'b0;
            s_data    <= '0;
        end else begin
            s_valid <= 1'b0;
            if (start_acc) begin
                h_q       <= h;
                has_aad_q <= has_aad;
                has_ct_q  <= has_ct;
                aad_cnt   <= '0;
                ct_cnt    <= '0;
                s_data    <= '0;
            end
            if (aad_hs) aad_cnt <= aad_cnt + CNT_W'(beat_bytes(aad_bytes, aad_last));
            if (ct_hs)  ct_cnt  <= ct_cnt + CNT_W'(beat_bytes(ct_bytes, ct_last));
            if (state == S_WAIT_Y && gh_y_valid && !abort) begin
                s_data  <= gh_y;
                s_valid <= 1'b1;
            end
        end
    end

endmodule
